// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision divider.
// Includes the normalize/round/pack step used once the quotient is ready.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int Q_W    = 27;
  localparam int E_W    = 10;
  localparam int ITERS  = 27;
  localparam int CNT_W  = 5;
  localparam int BIAS   = 127;

  localparam logic signed [E_W-1:0] E_OVF = 10'sd255;
  localparam logic signed [E_W-1:0] E_UNF = 10'sd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] q;
    logic        err;
  } res_t;

  function automatic res_t pack_result(
    input logic                  sign,
    input logic signed [E_W-1:0] e_diff,
    input logic [Q_W-1:0]        quo,
    input logic                  rem_nz
  );
    logic [FRAC_W-1:0]     frac;
    logic                  lsb;
    logic                  g;
    logic                  s;
    logic [FRAC_W:0]       sum;
    logic signed [E_W-1:0] e;
    res_t                  r;
    if (quo[Q_W-1]) begin
      frac = quo[Q_W-2:3];
      lsb  = quo[3];
      g    = quo[2];
      s    = |quo[1:0] | rem_nz;
      e    = e_diff + E_W'(BIAS);
    end else begin
      frac = quo[Q_W-3:2];
      lsb  = quo[2];
      g    = quo[1];
      s    = quo[0] | rem_nz;
      e    = e_diff + E_W'(BIAS - 1);
    end
    // hidden bit is always 1, so a carry out of the fraction is a mantissa carry
    sum = {1'b0, frac} + {{FRAC_W{1'b0}}, g & (s | lsb)};
    e   = e + {{(E_W-1){1'b0}}, sum[FRAC_W]};
    if (e >= E_OVF) begin
      r.q   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r.err = 1'b1;
    end else if (e <= E_UNF) begin
      r.q   = {sign, 31'b0};
      r.err = 1'b1;
    end else begin
      r.q   = {sign, e[EXP_W-1:0], sum[FRAC_W-1:0]};
      r.err = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring mantissa divider, one quotient bit per clock.
// quotient = floor(a * 2^(ITERS-1) / b), remainder is the true remainder.
module div_core
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              busy,
  output logic [Q_W-1:0]    quotient,
  output logic [MANT_W-1:0] remainder
);

  logic [MANT_W-1:0] r;
  logic [MANT_W-1:0] d;
  logic [Q_W-1:0]    quo;
  logic [CNT_W-1:0]  cnt;
  logic              first;
  logic [MANT_W:0]   op;
  logic              ge;

  // first step uses the dividend as-is, later steps the shifted remainder
  always_comb begin
    op = first ? {1'b0, r} : {r, 1'b0};
    ge = op >= {1'b0, d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      d     <= '0;
      quo   <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else if (load) begin
      r     <= a;
      d     <= b;
      quo   <= '0;
      cnt   <= CNT_W'(ITERS);
      first <= 1'b1;
    end else if (cnt != '0) begin
      r     <= MANT_W'(ge ? op - {1'b0, d} : op);
      quo   <= {quo[Q_W-2:0], ge};
      cnt   <= cnt - 1'b1;
      first <= 1'b0;
    end
  end

  assign busy      = cnt != '0;
  assign quotient  = quo;
  assign remainder = r;

endmodule

// File: rtl/f_div.sv
// IEEE-754 single-precision divider: IDLE/DIV/ROUND control around div_core.
// Zero operands bypass the iterative divide; denormals flush to zero.
module f_div
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        valid,
  output logic        busy,
  output logic        error_flag,
  output logic        div_zero
);

  state_t                state;
  logic [CNT_W-1:0]      iter;
  logic                  sign_r;
  logic [EXP_W-1:0]      ea_r;
  logic [EXP_W-1:0]      eb_r;
  logic                  az_r;
  logic                  bz_r;
  logic                  load;
  logic                  a_zero;
  logic                  b_zero;
  logic                  core_busy;
  logic [Q_W-1:0]        quotient;
  logic [MANT_W-1:0]     remainder;
  logic signed [E_W-1:0] e_diff;
  res_t                  res;

  assign a_zero = a[30:23] == '0;
  assign b_zero = b[30:23] == '0;
  assign load   = (state == IDLE) && start;
  assign e_diff = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r});

  div_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .a         ({1'b1, a[22:0]}),
    .b         ({1'b1, b[22:0]}),
    .busy      (core_busy),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    res = pack_result(sign_r, e_diff, quotient, |remainder);
    if (bz_r) begin
      res.q   = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      res.err = 1'b0;
    end else if (az_r) begin
      res.q   = {sign_r, 31'b0};
      res.err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      iter       <= '0;
      sign_r     <= 1'b0;
      ea_r       <= '0;
      eb_r       <= '0;
      az_r       <= 1'b0;
      bz_r       <= 1'b0;
      q          <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      error_flag <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_r <= a[31] ^ b[31];
            ea_r   <= a[30:23];
            eb_r   <= b[30:23];
            az_r   <= a_zero;
            bz_r   <= b_zero;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= (a_zero || b_zero) ? ROUND : DIV;
          end
        end
        DIV: begin
          iter <= iter + 1'b1;
          if (iter == CNT_W'(ITERS - 1) || !core_busy) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          q          <= res.q;
          error_flag <= res.err;
          div_zero   <= bz_r;
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_div.sv
// Scoreboard bench for f_div: expected results queued at issue, checked on valid.
module tb_f_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic        valid;
  logic        busy;
  logic        error_flag;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic        e;
    logic        d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  f_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .q          (q),
    .valid      (valid),
    .busy       (busy),
    .error_flag (error_flag),
    .div_zero   (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        check("q", q, x.q);
        check("error_flag", {31'b0, error_flag}, {31'b0, x.e});
        check("div_zero", {31'b0, div_zero}, {31'b0, x.d});
        check("latency", cyc - x.acc, x.lat);
        check("busy_at_valid", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] eq, input logic ee,
                       input logic ed, input int lat);
    exp_t x;
    int   n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_timeout", 32'd1, 32'd0);
    start = 1'b1;
    a     = ia;
    b     = ib;
    x.q   = eq;
    x.e   = ee;
    x.d   = ed;
    x.lat = lat;
    x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_q", q, 32'h0);
    check("rst_flags", {28'b0, valid, busy, error_flag, div_zero}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
    issue(32'hBF800000, 32'h40800000, 32'hBE800000, 1'b0, 1'b0, 28);
    issue(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 1);
    issue(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0, 28);
    issue(32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 1'b0, 28);
    issue(32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0, 28);
    issue(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 28);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 1'b1, 1'b0, 28);
    issue(32'h00000000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 1);
    issue(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1, 1);
    issue(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1);
    issue(32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 28);
    drain();

    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("q_hold", q, 32'h40400000);

    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_q", q, 32'h0);
    check("abort_flags", {28'b0, valid, busy, error_flag, div_zero}, 32'h0);
    rst = 1'b0;
    sb.delete();
    issue(32'hBF800000, 32'h40800000, 32'hBE800000, 1'b0, 1'b0, 28);
    drain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_div.md
F_DIV -- requirements
Module: f_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to divide a by b; accepted only while busy=0.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 SHALL have port q, output, 32 bits: registered quotient; holds until the next result.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when q is updated.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after acceptance until the cycle valid pulses.
REQ-009 SHALL have port error_flag, output, 1 bit: exponent overflow or underflow on the current q; held with q.
REQ-010 SHALL have port div_zero, output, 1 bit: divisor was zero on the current q; held with q.

Function
REQ-011 SHALL capture a and b into internal registers on the edge where start=1 and busy=0; start while busy=1 SHALL be ignored.
REQ-012 SHALL use FSM states IDLE, DIV, ROUND: IDLE->DIV on accept; DIV->ROUND after 27 iterations; ROUND->IDLE unconditionally.
REQ-013 SHALL take special-case operands IDLE->ROUND directly, skipping DIV.
REQ-014 SHALL compute sign = a[31]^b[31] and mantissas ma={1,a[22:0]}, mb={1,b[22:0]}.
REQ-015 SHALL treat exponent field 0 as zero, flushing denormals; exponent 255 is out of scope and SHALL be treated as a normal value.
REQ-016 SHALL have DIV run a restoring divide producing one quotient bit per cycle, Q = floor(ma*2^26/mb), 27 bits, plus the remainder.
REQ-017 SHALL normalize as follows: if Q[26]=1, significand = Q[26:3], guard = Q[2], sticky = |Q[1:0] | (rem!=0), and e = ea-eb+127; otherwise significand = Q[25:2], guard = Q[1], sticky = Q[0] | (rem!=0), and e = ea-eb+126.
REQ-018 SHALL round to nearest even: increment when guard & (sticky | lsb); a mantissa carry-out SHALL increment e and zero the fraction.
REQ-019 SHALL compute e as a 10-bit signed value; e>=255 SHALL give q={sign,0xFF,0} with error_flag=1; e<=0 SHALL give q={sign,31'b0} with error_flag=1.
REQ-020 SHALL give q={sign,31'b0}, error_flag=0 and div_zero=0 when a is zero and b is nonzero.
REQ-021 SHALL give q={sign,0xFF,23'b0} and div_zero=1 when b is zero, whether or not a is zero.
REQ-022 SHALL register q, valid, error_flag and div_zero in ROUND; normal latency is 28 cycles from accept to valid, special-case latency is 1.
REQ-023 SHALL accept start again in the cycle valid is high, because busy=0 in that cycle.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set the FSM to IDLE and set q=0, valid=0, busy=0, error_flag=0 and div_zero=0.
REQ-025 SHALL let rst mid-operation abort the division with no valid pulse; start SHALL be accepted the cycle after rst deasserts.

Structure
REQ-026 SHALL place FSM state encodings, the exponent bias (127), the iteration count (27) and the field widths in shared package fp_pkg.
REQ-027 SHALL implement the iterative mantissa divider as sub-module div_core (ports clk, rst, load, a, b, busy, quotient, remainder), mirroring the sequential multiplier core.

Verification
REQ-028 SHALL be checked with a=0x40C00000, b=0x40000000, start: valid after 28 cycles with q=0x40400000, flags 0.
REQ-029 SHALL be checked with a=0x3F800000, b=0x40400000: q=0x3EAAAAAB (round-up path).
REQ-030 SHALL be checked with a=0xBF800000, b=0x40800000: q=0xBE800000; then a=0x00000000, b=0x40000000: q=0x00000000, valid 1 cycle after accept.
REQ-031 SHALL be checked with a=0x3F800000, b=0x00000000: q=0x7F800000, div_zero=1, valid 1 cycle after accept.
REQ-032 SHALL be checked with a=0x7F000000, b=0x00800000: q=0x7F800000, error_flag=1; a=0x00800000, b=0x7F000000: q=0x00000000, error_flag=1.
REQ-033 SHALL be checked by a second start during busy (ignored) and rst at cycle 10 of DIV: no valid, all outputs 0, next start completes correctly.
